// File: rtl/mult_pkg.sv
// Shared constants, Booth select encodings and tree-sizing helpers
// for the pipelined Booth/Wallace multiplier.
package mult_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_N1,
    BOOTH_N2
  } booth_sel_e;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 3;

  function automatic int num_pp(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int csa_next(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int ops_at(input int n, input int lvl);
    int m;
    m = n;
    for (int i = 0; i < lvl; i++) m = csa_next(m);
    return m;
  endfunction

  function automatic int csa_levels(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = csa_next(m);
      l++;
    end
    return l;
  endfunction

  // Tree level whose carry-save vectors get the mid-tree register.
  function automatic int cut_level(input int levels, input int stages);
    return (stages >= 2) ? levels / 2 : levels;
  endfunction

  function automatic bit has_tree_reg(input int stages);
    return stages >= 2;
  endfunction

  function automatic bit has_cpa_reg(input int stages);
    return stages == MAX_STAGES;
  endfunction

  function automatic booth_sel_e booth_enc(input logic [2:0] t);
    booth_sel_e s;
    unique case (t)
      3'b001, 3'b010: s = BOOTH_P1;
      3'b011:         s = BOOTH_P2;
      3'b100:         s = BOOTH_N2;
      3'b101, 3'b110: s = BOOTH_N1;
      default:        s = BOOTH_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mult_pipe_unit_csa32_row.sv
// One 3:2 carry-save compressor row; carry comes out pre-shifted
// so both outputs align with the inputs.
module csa32_row
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum = a ^ b ^ c;

  assign carry = {(a[W-2:0] & b[W-2:0]) |
                  (a[W-2:0] & c[W-2:0]) |
                  (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/mult_pipe_unit.sv
// Pipelined radix-4 Booth / 3:2 CSA multiplier with valid/ready,
// stall, flush and tag. MULT_ACC_EN adds a fused accumulate operand.
module mult_pipe_unit
  import mult_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic               sign_en,
  input  logic [TAG_W-1:0]   tag_in,
`ifdef MULT_ACC_EN
  input  logic               acc_en,
  input  logic [2*WIDTH-1:0] acc_in,
`endif
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int NPP  = num_pp(WIDTH);
`ifdef MULT_ACC_EN
  localparam int NACC = 1;
`else
  localparam int NACC = 0;
`endif
  localparam int NOPS = NPP + 1 + NACC;
  localparam int LVLS = csa_levels(NOPS);
  localparam int CUT  = cut_level(LVLS, PIPE_STAGES);

  logic                   adv;
  logic [PIPE_STAGES-1:0] v;
  logic [TAG_W-1:0]       tag_q [PIPE_STAGES];

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv & !flush;
  assign out_valid = v[PIPE_STAGES-1];
  assign tag_out   = tag_q[PIPE_STAGES-1];
  assign busy      = |v;

  logic [WIDTH+1:0] xe;
  logic [WIDTH+1:0] ye;
  logic [WIDTH+2:0] yb;
  logic [PW-1:0]    xw;

  assign xe = {{2{sign_en & op1[WIDTH-1]}}, op1};
  assign ye = {{2{sign_en & op2[WIDTH-1]}}, op2};
  assign yb = {ye, 1'b0};
  assign xw = {{(PW-WIDTH-2){xe[WIDTH+1]}}, xe};

  logic [PW-1:0] ops0 [NOPS];
  logic [PW-1:0] negv;
  logic [PW-1:0] mag;
  booth_sel_e    sel;

  // Negative selects use ~X; the +1 lands in negv as one extra operand.
  always_comb begin
    negv = '0;
    mag  = '0;
    sel  = BOOTH_ZERO;
    for (int k = 0; k < NOPS; k++) ops0[k] = '0;
    for (int i = 0; i < NPP; i++) begin
      sel = booth_enc(yb[2*i +: 3]);
      unique case (sel)
        BOOTH_P1: mag = xw;
        BOOTH_P2: mag = xw << 1;
        BOOTH_N1: mag = ~xw;
        BOOTH_N2: mag = ~(xw << 1);
        default:  mag = '0;
      endcase
      ops0[i]   = mag << (2 * i);
      negv[2*i] = (sel == BOOTH_N1) || (sel == BOOTH_N2);
    end
    ops0[NPP] = negv;
`ifdef MULT_ACC_EN
    ops0[NPP+1] = acc_en ? acc_in : '0;
`endif
  end

  logic [PW-1:0] lvl  [LVLS+1][NOPS];
  logic [PW-1:0] src  [LVLS+1][NOPS];
  logic [PW-1:0] s1_q [NOPS];

  for (genvar k = 0; k < NOPS; k++) begin : g_l0
    assign lvl[0][k] = ops0[k];
  end

  for (genvar l = 0; l <= LVLS; l++) begin : g_src
    for (genvar k = 0; k < NOPS; k++) begin : g_k
      if (has_tree_reg(PIPE_STAGES) && l == CUT) begin : g_reg
        assign src[l][k] = s1_q[k];
      end else begin : g_wire
        assign src[l][k] = lvl[l][k];
      end
    end
  end

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int N  = ops_at(NOPS, l);
    localparam int G  = N / 3;
    localparam int NN = ops_at(NOPS, l + 1);
    for (genvar g = 0; g < G; g++) begin : g_csa
      csa32_row #(.W(PW)) u_csa (
        .a    (src[l][3*g]),
        .b    (src[l][3*g+1]),
        .c    (src[l][3*g+2]),
        .sum  (lvl[l+1][2*g]),
        .carry(lvl[l+1][2*g+1])
      );
    end
    for (genvar k = 2 * G; k < NOPS; k++) begin : g_pass
      if (k < NN) begin : g_thru
        assign lvl[l+1][k] = src[l][G + k];
      end else begin : g_zero
        assign lvl[l+1][k] = '0;
      end
    end
  end

  if (has_tree_reg(PIPE_STAGES)) begin : g_s1
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k < NOPS; k++) s1_q[k] <= '0;
      end else if (adv) begin
        for (int k = 0; k < NOPS; k++) s1_q[k] <= lvl[CUT][k];
      end
    end
  end else begin : g_no_s1
    for (genvar k = 0; k < NOPS; k++) begin : g_tie
      assign s1_q[k] = '0;
    end
  end

  logic [PW-1:0] fin_s;
  logic [PW-1:0] fin_c;

  if (has_cpa_reg(PIPE_STAGES)) begin : g_s2
    logic [PW-1:0] s2_s;
    logic [PW-1:0] s2_c;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        s2_s <= '0;
        s2_c <= '0;
      end else if (adv) begin
        s2_s <= src[LVLS][0];
        s2_c <= src[LVLS][1];
      end
    end
    assign fin_s = s2_s;
    assign fin_c = s2_c;
  end else begin : g_no_s2
    assign fin_s = src[LVLS][0];
    assign fin_c = src[LVLS][1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= '0;
    end else if (adv) begin
      out <= fin_s + fin_c;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) tag_q[k] <= '0;
    end else begin
      if (flush) begin
        v <= '0;
      end else if (adv) begin
        v[0] <= in_valid;
        for (int k = 1; k < PIPE_STAGES; k++) v[k] <= v[k-1];
      end
      if (adv) begin
        tag_q[0] <= tag_in;
        for (int k = 1; k < PIPE_STAGES; k++) tag_q[k] <= tag_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe_unit.sv
// Directed bench for mult_pipe_unit (WIDTH=32, PIPE_STAGES=2):
// products, latency, stall, flush and async reset.
module tb_mult_pipe_unit;

  localparam int W  = 32;
  localparam int P  = 2;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op1;
  logic [W-1:0]  op2;
  logic          sign_en;
  logic [TW-1:0] tag_in;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] res;
  logic [TW-1:0] tag_out;
  logic          busy;
`ifdef MULT_ACC_EN
  logic          acc_en;
  logic [2*W-1:0] acc_in;
`endif

  always #5 clk = ~clk;

  mult_pipe_unit #(
    .WIDTH      (W),
    .PIPE_STAGES(P),
    .TAG_W      (TW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .sign_en  (sign_en),
    .tag_in   (tag_in),
`ifdef MULT_ACC_EN
    .acc_en   (acc_en),
    .acc_in   (acc_in),
`endif
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (res),
    .tag_out  (tag_out),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic s,
                        input logic [4:0] tg, input logic [63:0] exp);
    int lat;
    op1      = a;
    op2      = b;
    sign_en  = s;
    tag_in   = tg;
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(P));
    chk({tag, "_out"}, res, exp);
    chk({tag, "_tag"}, 64'(tag_out), 64'(tg));
    tick();
  endtask

  logic [4:0]  got_tag [$];
  logic [63:0] got_res [$];
  logic        acc_now;
  logic        take_now;
  int          nxt;
  int          nval;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_valid  = 1'b0;
    op1       = '0;
    op2       = '0;
    sign_en   = 1'b0;
    tag_in    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
`ifdef MULT_ACC_EN
    acc_en    = 1'b0;
    acc_in    = '0;
`endif
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", res, 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rstn = 1'b1;
    tick();
    chk("idle_rdy", 64'(in_ready), 64'd1);

    run_op("s_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd7,
           64'h0000000000000001);
    run_op("u_m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd8,
           64'hFFFFFFFE00000001);
    run_op("s_min1", 32'h80000000, 32'h00000001, 1'b1, 5'd9,
           64'hFFFFFFFF80000000);
    run_op("s_max2", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 5'd10,
           64'h3FFFFFFF00000001);
    run_op("s_min2", 32'h80000000, 32'h80000000, 1'b1, 5'd11,
           64'h4000000000000000);
    run_op("u_min2", 32'h80000000, 32'h80000000, 1'b0, 5'd12,
           64'h4000000000000000);
    run_op("s_neg6", 32'hFFFFFFFE, 32'h00000003, 1'b1, 5'd13,
           64'hFFFFFFFFFFFFFFFA);
    run_op("u_x2", 32'hFFFFFFFF, 32'h00000002, 1'b0, 5'd14,
           64'h00000001FFFFFFFE);
    run_op("s_m1min", 32'hFFFFFFFF, 32'h80000000, 1'b1, 5'd15,
           64'h0000000080000000);
    run_op("u_zero", 32'h00000000, 32'hFFFFFFFF, 1'b0, 5'd16,
           64'h0000000000000000);
    run_op("u_x16", 32'h12345678, 32'h00000010, 1'b0, 5'd17,
           64'h0000000123456780);
    run_op("s_m1max", 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 5'd18,
           64'hFFFFFFFF80000001);
    run_op("u_m1max", 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 5'd19,
           64'h7FFFFFFE80000001);

    // back-to-back stream, consumer stalls in cycles 3..6
    nxt = 1;
    for (int c = 1; c <= 16; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (nxt <= 4);
      op1       = 32'(nxt * 3);
      op2       = 32'(nxt + 100);
      sign_en   = 1'b0;
      tag_in    = 5'(nxt);
      #1;
      if (c >= 3 && c <= 6) begin
        chk("stall_rdy", 64'(in_ready), 64'd0);
        chk("stall_vld", 64'(out_valid), 64'd1);
        chk("stall_tag", 64'(tag_out), 64'd1);
        chk("stall_out", res, 64'd303);
      end
      acc_now  = in_valid & in_ready;
      take_now = out_valid & out_ready;
      if (take_now) begin
        got_tag.push_back(tag_out);
        got_res.push_back(res);
      end
      @(posedge clk);
      #1;
      if (acc_now) nxt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_cnt", 64'(got_tag.size()), 64'd4);
    for (int i = 0; i < got_tag.size(); i++) begin
      chk("strm_tag", 64'(got_tag[i]), 64'(i + 1));
      chk("strm_out", got_res[i], 64'((i + 1) * 3 * (i + 101)));
    end

    // two ops in flight, then flush
    op1 = 32'd5; op2 = 32'd6; sign_en = 1'b0;
    tag_in = 5'd20; in_valid = 1'b1;
    tick();
    chk("fl_busy_pre", 64'(busy), 64'd1);
    op1 = 32'd7; tag_in = 5'd21;
    tick();
    tag_in = 5'd22; flush = 1'b1;
    #1;
    chk("fl_rdy", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    nval = 0;
    repeat (2) begin
      tick();
      if (out_valid) nval++;
    end
    chk("fl_busy2", 64'(busy), 64'd0);
    chk("fl_noout", 64'(nval), 64'd0);
    run_op("post_fl", 32'd9, 32'd9, 1'b0, 5'd23, 64'd81);

    // async reset with ops in flight
    op1 = 32'h11; op2 = 32'h3; sign_en = 1'b0;
    tag_in = 5'd24; in_valid = 1'b1;
    tick();
    op1 = 32'h22; tag_in = 5'd25;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #3;
    chk("ar_pre_vld", 64'(out_valid), 64'd1);
    chk("ar_pre_out", res, 64'h33);
    rstn = 1'b0;
    #1;
    chk("ar_vld", 64'(out_valid), 64'd0);
    chk("ar_out", res, 64'd0);
    chk("ar_tag", 64'(tag_out), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    #2;
    rstn = 1'b1;
    out_ready = 1'b1;
    nval = 0;
    repeat (6) begin
      tick();
      if (out_valid) nval++;
    end
    chk("ar_noout", 64'(nval), 64'd0);

`ifdef MULT_ACC_EN
    acc_en = 1'b1;
    acc_in = 64'h10;
    run_op("mac", 32'd3, 32'd5, 1'b0, 5'd26, 64'h1F);
    acc_en = 1'b0;
`endif
    run_op("final", 32'hFFFFFFFD, 32'h00000004, 1'b1, 5'd27,
           64'hFFFFFFFFFFFFFFF4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
